// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide sequencer.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package ex_muldiv_sequencer_pkg;

    // One quotient or product bit per iteration for a 32-bit datapath.
    localparam int MD_ITERATIONS = 32;

    // RV32M funct3 encoding.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_opcode_e;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2,
        MD_DONE  = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input md_opcode_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic md_a_signed(input md_opcode_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM (MULHSU takes it unsigned).
    function automatic logic md_b_signed(input md_opcode_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_md_iter_step.sv
// One unsigned shift-add multiply step or restoring shift-subtract divide step.
// Latency: combinational.
// Backpressure: none; the caller decides when to register acc_out.
// Ports: acc_in/acc_out = 2*XLEN accumulator, operand_in = multiplicand or
// divisor magnitude, div_mode = 1 selects the divide step.
module md_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand_in,
    input  logic              div_mode,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_top;
    logic [XLEN:0] div_diff;

    always_comb begin
        // Multiply: {high, low} where low still holds unconsumed multiplier
        // bits; add the multiplicand into high when the next bit is set, then
        // shift the whole register right, keeping the carry.
        mul_sum  = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand_in} : '0);

        // Divide: {remainder, dividend/quotient}. Shifting left by one brings
        // the next dividend bit into the remainder; the top bit of the
        // difference is the borrow because the remainder is always < divisor.
        div_top  = acc_in[2*XLEN-1:XLEN-1];
        div_diff = div_top - {1'b0, operand_in};

        acc_out  = '0;
        if (div_mode) begin
            if (div_diff[XLEN]) begin
                acc_out = {div_top[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end else begin
                acc_out = {div_diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_out = {mul_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage RV32M multiply/divide sequencer, one bit per cycle.
// Latency: result strobe N+34 after issue (N+1 for divide-by-zero / DIV overflow).
// Backpressure: stall_op holds IF/ID/EX while computing; flush_ip aborts at once.
// Ports: md_*_ip = EX operands/opcode/rd, flush_ip = abort; stall_op/busy_op =
// pipeline control, md_result_op/md_valid_op/md_write_reg_addr_op = write-back.
module ex_muldiv_sequencer
    import ex_muldiv_sequencer_pkg::*;
#(
    parameter int XLEN   = MD_ITERATIONS,
    parameter int ITER_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            md_enable_ip,
    input  logic [2:0]      md_operator_ip,
    input  logic [XLEN-1:0] md_operand_a_ip,
    input  logic [XLEN-1:0] md_operand_b_ip,
    input  logic [4:0]      md_write_reg_addr_ip,
    input  logic            flush_ip,
    output logic            stall_op,
    output logic            busy_op,
    output logic [XLEN-1:0] md_result_op,
    output logic            md_valid_op,
    output logic [4:0]      md_write_reg_addr_op
);

    localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [ITER_W-1:0] LAST_CNT = ITER_W'(XLEN-1);

    md_state_e         state_q, state_d;
    logic [ITER_W-1:0] count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    md_opcode_e        op_q, op_d;
    logic              neg_q, neg_d;          // negate product / quotient
    logic              neg_rem_q, neg_rem_d;  // negate remainder (dividend sign)
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        wb_addr_q, wb_addr_d;

    md_opcode_e        op_in;
    logic              a_neg, b_neg, is_div_in, div_by_zero, div_ovf;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;
    logic              stall_c;

    // Issue-side decode of the operands as presented in EX.
    assign op_in       = md_opcode_e'(md_operator_ip);
    assign a_neg       = md_a_signed(op_in) & md_operand_a_ip[XLEN-1];
    assign b_neg       = md_b_signed(op_in) & md_operand_b_ip[XLEN-1];
    assign abs_a       = a_neg ? -md_operand_a_ip : md_operand_a_ip;
    assign abs_b       = b_neg ? -md_operand_b_ip : md_operand_b_ip;
    assign is_div_in   = md_is_div(op_in);
    assign div_by_zero = is_div_in & (md_operand_b_ip == '0);
    assign div_ovf     = (op_in == MD_DIV || op_in == MD_REM) &&
                         (md_operand_a_ip == INT_MIN) && (md_operand_b_ip == '1);

    md_iter_step #(.XLEN(XLEN)) u_step (
        .acc_in     (acc_q),
        .operand_in (opnd_q),
        .div_mode   (md_is_div(op_q)),
        .acc_out    (acc_step)
    );

    // Sign fixup; the full product is negated so MULH* high words are exact.
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_result = rem_fix;
        case (op_q)
            MD_MUL:                       fix_result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_result = quo_fix;
            default:                      fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        rd_d      = rd_q;
        result_d  = result_q;
        wb_addr_d = wb_addr_q;
        stall_c   = 1'b0;

        if (flush_ip) begin
            state_d = MD_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_enable_ip) begin
                        stall_c   = 1'b1;
                        count_d   = '0;
                        op_d      = op_in;
                        rd_d      = md_write_reg_addr_ip;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        if (is_div_in) begin
                            acc_d  = {{XLEN{1'b0}}, abs_a};
                            opnd_d = abs_b;
                        end else begin
                            acc_d  = {{XLEN{1'b0}}, abs_b};
                            opnd_d = abs_a;
                        end
                        if (div_by_zero) begin
                            result_d  = (op_in inside {MD_DIV, MD_DIVU}) ? '1 : md_operand_a_ip;
                            wb_addr_d = md_write_reg_addr_ip;
                            state_d   = MD_DONE;
                        end else if (div_ovf) begin
                            result_d  = (op_in == MD_DIV) ? INT_MIN : '0;
                            wb_addr_d = md_write_reg_addr_ip;
                            state_d   = MD_DONE;
                        end else begin
                            state_d   = MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    stall_c = 1'b1;
                    acc_d   = acc_step;
                    count_d = count_q + ITER_W'(1);
                    if (count_q == LAST_CNT) begin
                        count_d = '0;
                        state_d = MD_FIXUP;
                    end
                end
                MD_FIXUP: begin
                    stall_c   = 1'b1;
                    result_d  = fix_result;
                    wb_addr_d = rd_q;
                    state_d   = MD_DONE;
                end
                // The instruction that produced the result is still in EX,
                // so md_enable_ip must not restart it here.
                default: begin
                    state_d = MD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= MD_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= MD_MUL;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_q      <= '0;
            result_q  <= '0;
            wb_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            wb_addr_q <= wb_addr_d;
        end
    end

    // stall is combinational from md_enable_ip; gate it so it also reads 0
    // while reset is held.
    assign stall_op             = reset & stall_c;
    assign busy_op              = (state_q != MD_IDLE);
    assign md_valid_op          = (state_q == MD_DONE) & ~flush_ip;
    assign md_result_op         = result_q;
    assign md_write_reg_addr_op = wb_addr_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
module tb_ex_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        md_enable_ip = 1'b0;
    logic [2:0]  md_operator_ip = '0;
    logic [31:0] md_operand_a_ip = '0;
    logic [31:0] md_operand_b_ip = '0;
    logic [4:0]  md_write_reg_addr_ip = '0;
    logic        flush_ip = 1'b0;
    logic        stall_op, busy_op, md_valid_op;
    logic [31:0] md_result_op;
    logic [4:0]  md_write_reg_addr_op;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_result = '0;

    ex_muldiv_sequencer dut (
        .clock                (clock),
        .reset                (reset),
        .md_enable_ip         (md_enable_ip),
        .md_operator_ip       (md_operator_ip),
        .md_operand_a_ip      (md_operand_a_ip),
        .md_operand_b_ip      (md_operand_b_ip),
        .md_write_reg_addr_ip (md_write_reg_addr_ip),
        .flush_ip             (flush_ip),
        .stall_op             (stall_op),
        .busy_op              (busy_op),
        .md_result_op         (md_result_op),
        .md_valid_op          (md_valid_op),
        .md_write_reg_addr_op (md_write_reg_addr_op)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics from 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, sq;
        logic [63:0] ux, uy, p;
        sx = $signed({{32{x[31]}}, x});
        sy = $signed({{32{y[31]}}, y});
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: begin p = sx * sy; return p[31:0];  end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * $signed(uy); return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                sq = sx / sy; p = sq; return p[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                sq = sx % sy; p = sq; return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic logic is_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return (o[2] && y == 0) ||
               ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    // Issue one op in cycle N, keep it presented until the strobe, then check
    // latency, stall span, result, rd and that DONE does not restart it.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
        logic [31:0] exp;
        int          exp_lat, lat, stalls;
        logic        got;
        logic [31:0] res;
        logic [4:0]  addr;
        exp     = model(o, x, y);
        exp_lat = is_fast(o, x, y) ? 1 : 34;
        lat = -1; stalls = 0; got = 1'b0; res = '0; addr = '0;
        @(posedge clock); #1;
        md_enable_ip = 1'b1; md_operator_ip = o; md_operand_a_ip = x;
        md_operand_b_ip = y; md_write_reg_addr_ip = r;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (stall_op) stalls++;
            if (md_valid_op) begin
                got = 1'b1; lat = c; res = md_result_op; addr = md_write_reg_addr_op;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        md_enable_ip = 1'b0;
        @(negedge clock);
        check($sformatf("op%0d valid_seen", o), {31'b0, got}, 32'd1);
        check($sformatf("op%0d latency", o), lat, exp_lat);
        check($sformatf("op%0d stall_cycles", o), stalls, exp_lat);
        check($sformatf("op%0d a=%h b=%h result", o, x, y), res, exp);
        check($sformatf("op%0d wb_addr", o), {27'b0, addr}, {27'b0, r});
        check($sformatf("op%0d no_restart_busy", o), {31'b0, busy_op}, 32'd0);
        if (got) last_result = exp;
    endtask

    task automatic flush_test;
        int vcount;
        @(posedge clock); #1;
        md_enable_ip = 1'b1; md_operator_ip = 3'd0;
        md_operand_a_ip = $urandom; md_operand_b_ip = $urandom; md_write_reg_addr_ip = 5'd9;
        // Issue cycle is N; the 10th calculation cycle is N+10.
        repeat (10) @(posedge clock);
        #1 flush_ip = 1'b1;
        @(negedge clock);
        check("flush busy_before", {31'b0, busy_op}, 32'd1);
        check("flush stall", {31'b0, stall_op}, 32'd0);
        check("flush valid", {31'b0, md_valid_op}, 32'd0);
        @(posedge clock); #1;
        flush_ip = 1'b0; md_enable_ip = 1'b0;
        @(negedge clock);
        check("flush busy_after", {31'b0, busy_op}, 32'd0);
        vcount = 0;
        repeat (40) begin
            @(negedge clock);
            if (md_valid_op) vcount++;
        end
        check("flush no_valid", vcount, 0);
        check("flush result_held", md_result_op, last_result);
    endtask

    task automatic reset_test;
        @(posedge clock); #1;
        md_enable_ip = 1'b1; md_operator_ip = 3'd0;
        md_operand_a_ip = 32'h1234_5678; md_operand_b_ip = 32'h9abc_def0; md_write_reg_addr_ip = 5'd17;
        repeat (15) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("rst_mid stall", {31'b0, stall_op}, 32'd0);
        check("rst_mid busy", {31'b0, busy_op}, 32'd0);
        check("rst_mid valid", {31'b0, md_valid_op}, 32'd0);
        check("rst_mid result", md_result_op, 32'd0);
        check("rst_mid wb_addr", {27'b0, md_write_reg_addr_op}, 32'd0);
        md_enable_ip = 1'b0;
        @(posedge clock); #2;
        reset = 1'b1;
        last_result = '0;
        run_op(3'd3, 32'd3, 32'd5, 5'd4);
        run_op(3'd0, 32'd3, 32'd5, 5'd5);
    endtask

    localparam int N_DIR = 13;
    logic [2:0]  dir_op [N_DIR] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7,
                                    3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] dir_a  [N_DIR] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                    32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dir_b  [N_DIR] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'd2, 32'd2, 32'd7, 32'd7,
                                    32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset stall", {31'b0, stall_op}, 32'd0);
        check("reset busy", {31'b0, busy_op}, 32'd0);
        check("reset valid", {31'b0, md_valid_op}, 32'd0);
        check("reset result", md_result_op, 32'd0);
        check("reset wb_addr", {27'b0, md_write_reg_addr_op}, 32'd0);
        #14 reset = 1'b1;

        for (int i = 0; i < N_DIR; i++) run_op(dir_op[i], dir_a[i], dir_b[i], 5'(i + 1));

        flush_test();
        run_op(3'd0, $urandom, $urandom, 5'd11);

        reset_test();

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op(ro, ra, rb, 5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for the RV32M multiply/divide instructions in the EX stage.
- Sits beside the ALU and receives the same post-forwarding operands the ALU sees.
- Iterates one bit per cycle and stalls the IF/ID/EX pipeline registers until the result is ready.
- Delivers a registered result and write-back address for the EX-MEM buffer.

Parameters:
XLEN, 32, operand/result width
ITER_W, 6, width of iteration counter (counts 0..XLEN-1)

Ports:
clock  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
md_enable_ip  in  1  EX instruction is an M-extension op
md_operator_ip  in  3  md_opcode_e (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
md_operand_a_ip  in  XLEN  rs1 value after forwarding mux
md_operand_b_ip  in  XLEN  rs2 value after forwarding mux
md_write_reg_addr_ip  in  5  destination register
flush_ip  in  1  abort current operation (flush controller)
stall_op  out  1  hold IF/ID/EX pipeline registers
busy_op  out  1  state != MD_IDLE
md_result_op  out  XLEN  final result, registered
md_valid_op  out  1  one-cycle result strobe
md_write_reg_addr_op  out  5  destination register of the result

Behaviour:
- Reset (reset=0, asynchronous): state MD_IDLE, counter 0; stall_op, busy_op, md_result_op, md_valid_op, md_write_reg_addr_op all 0.
- States: MD_IDLE, MD_CALC, MD_FIXUP, MD_DONE.
- MD_IDLE, on md_enable_ip=1 and flush_ip=0 in cycle N:
  - latch |a|, |b|, result signs (signed per op; MULHSU: a signed, b unsigned), opcode, rd; counter=0.
  - divisor==0 (DIV/DIVU/REM/REMU) -> MD_DONE directly; quotient=all ones, remainder=a.
  - DIV/REM with a=0x80000000, b=0xFFFFFFFF -> MD_DONE directly; quotient=0x80000000, remainder=0.
  - otherwise -> MD_CALC.
- MD_CALC, one bit per cycle:
  - multiply: shift-add on a 2*XLEN product register.
  - divide: restoring shift-subtract on a 2*XLEN remainder/quotient register.
  - counter increments each cycle; at counter==XLEN-1 -> MD_FIXUP.
- MD_FIXUP: conditionally negate (two's complement) and select low word (MUL), high word (MULH*), quotient (DIV*) or remainder (REM*). Register into md_result_op; -> MD_DONE.
- MD_DONE: md_valid_op=1 for exactly one cycle; md_write_reg_addr_op valid; -> MD_IDLE unconditionally. md_enable_ip is ignored in MD_DONE because the same instruction is still in EX.
- stall_op (combinational): (MD_IDLE & md_enable_ip & ~flush_ip) | MD_CALC | MD_FIXUP. It is 0 in MD_DONE so the instruction advances.
- Latency, normal path: valid at cycle N+34; stall_op high in cycles N..N+33 (34 cycles).
- Latency, fast path: valid at N+1; stall_op high in cycle N only.
- md_result_op and md_write_reg_addr_op hold their values until the next MD_FIXUP or fast-path load.
- flush_ip=1 in any state has priority:
  - stall_op forced 0 in the same cycle; md_valid_op forced 0.
  - next state MD_IDLE; counter cleared; md_result_op unchanged.
- reset asserted mid-operation: immediate return to the reset values; no valid is produced.
- All arithmetic is modulo 2^XLEN except the internal 2*XLEN accumulator; negation of 0x80000000 wraps to itself.

Decomposition:
- CORE_PKG gains:
  - md_opcode_e (3-bit enum, RV32M funct3 encoding: MUL=0 … REMU=7)
  - md_state_e (2-bit enum)
  - localparam MD_ITERATIONS = 32
- One combinational sub-module, md_iter_step: takes the accumulator, operand and mode, and returns the next accumulator for one multiply or divide step.
- FSM, counter, sign/fixup and special-case logic stay in ex_muldiv_sequencer.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) at cycle N -> stall_op high N..N+33, md_valid_op pulse at N+34, md_result_op=0xFFFFFFEB.
- a=b=0xFFFFFFFF -> MULHU 0xFFFFFFFE; MULH 0x00000000; MULHSU 0xFFFFFFFF; MUL 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 0x00000005, each valid at N+1 with stall only in cycle N. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; valid at N+1.
- Flush and back-to-back:
  - flush_ip pulsed at the 10th MD_CALC cycle -> stall_op 0 that cycle, busy_op 0 next cycle, no md_valid_op.
  - a new MUL issued right after is correct.
  - md_enable_ip held high through MD_DONE does not restart.
- reset driven low mid-MD_CALC -> all outputs 0 asynchronously, before the next clock edge. After release, MULHU 3*5 -> 0x00000000 and MUL 3*5 -> 0x0000000F, correct.
